// File: rtl/vec_seq_ctrl.sv
// Test-vector sequencer for a 3-input combinational block (a,b,c -> z).
// Plays a DEPTH-entry {a,b,c,exp} table, holds each vector HOLD cycles, and tallies mismatches.
module vec_seq_ctrl #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3,
  parameter int HOLD   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [3:0]        wr_data,
  input  logic              start,
  input  logic              abort,
  input  logic              z_in,
  output logic              a_out,
  output logic              b_out,
  output logic              c_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W:0]   err_cnt,
  output logic [ADDR_W-1:0] err_first,
  output logic              err_valid
);

  localparam int HC_W = (HOLD > 1) ? $clog2(HOLD) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, state_nx;
  logic [3:0]        tbl [DEPTH];
  logic [ADDR_W-1:0] idx;
  logic [HC_W-1:0]   hc;
  logic              wr_acc, start_acc, sample, last, mism;
  logic [2:0]        row0_abc, nxt_abc;

  assign wr_acc    = wr_en && (state != RUN);
  assign start_acc = start && !abort && (state != RUN);
  assign sample    = (state == RUN) && (hc == HC_W'(HOLD - 1));
  assign last      = sample && (idx == ADDR_W'(DEPTH - 1));
  assign mism      = z_in != tbl[idx][0];

  // A write landing on the start edge must be visible in the first vector.
  assign row0_abc  = (wr_acc && wr_addr == '0) ? wr_data[3:1] : tbl[0][3:1];
  assign nxt_abc   = tbl[idx + ADDR_W'(1)][3:1];

  assign busy = (state == RUN);
  assign done = (state == DONE);

  // Table storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_acc) tbl[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (abort) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE, DONE: if (start) state_nx = RUN;
        RUN:        if (last)  state_nx = DONE;
        default:    state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx                   <= '0;
      hc                    <= '0;
      {a_out, b_out, c_out} <= 3'b000;
      pass                  <= 1'b0;
      err_cnt               <= '0;
      err_first             <= '0;
      err_valid             <= 1'b0;
    end else if (abort) begin
      // Error tallies survive an abort so the partial run can be inspected.
      idx                   <= '0;
      hc                    <= '0;
      {a_out, b_out, c_out} <= 3'b000;
      pass                  <= 1'b0;
    end else if (start_acc) begin
      idx                   <= '0;
      hc                    <= '0;
      {a_out, b_out, c_out} <= row0_abc;
      pass                  <= 1'b0;
      err_cnt               <= '0;
      err_first             <= '0;
      err_valid             <= 1'b0;
    end else if (state == RUN) begin
      if (sample) begin
        hc <= '0;
        if (mism) begin
          err_cnt <= err_cnt + (ADDR_W+1)'(1);
          if (!err_valid) begin
            err_first <= idx;
            err_valid <= 1'b1;
          end
        end
        if (last) begin
          {a_out, b_out, c_out} <= 3'b000;
          pass                  <= (err_cnt == '0) && !mism;
        end else begin
          idx                   <= idx + ADDR_W'(1);
          {a_out, b_out, c_out} <= nxt_abc;
        end
      end else begin
        hc <= hc + HC_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_vec_seq_ctrl.sv
// Bench for vec_seq_ctrl: drives z=(a&b)|~(b&~c) as the block under test and checks
// each run against a table-level model of which entries should mismatch.
module tb_vec_seq_ctrl;

  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;
  localparam int HOLD   = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              wr_en = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [3:0]        wr_data = '0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic              z_in;
  logic              a_out, b_out, c_out, busy, done, pass, err_valid;
  logic [ADDR_W:0]   err_cnt;
  logic [ADDR_W-1:0] err_first;

  int checks = 0;
  int failures = 0;
  logic [3:0] mdl [DEPTH];

  vec_seq_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .HOLD(HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .abort(abort), .z_in(z_in), .a_out(a_out), .b_out(b_out),
    .c_out(c_out), .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
    .err_first(err_first), .err_valid(err_valid)
  );

  always #5 clk = ~clk;

  assign z_in = (a_out & b_out) | ~(b_out & ~c_out);

  function automatic logic zf(input logic [2:0] v);
    return (v[2] & v[1]) | ~(v[1] & ~v[0]);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Mismatch tally over the first n table entries.
  task automatic calc(input int n, output int ec, output int ef, output bit ev);
    ec = 0; ef = 0; ev = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (mdl[i][0] != zf(mdl[i][3:1])) begin
        if (!ev) ef = i;
        ev = 1'b1;
        ec++;
      end
    end
  endtask

  task automatic load_tbl;
    for (int i = 0; i < DEPTH; i++) begin
      wr_en = 1'b1; wr_addr = ADDR_W'(i); wr_data = mdl[i];
      tick;
    end
    wr_en = 1'b0;
  endtask

  task automatic truth_tbl;
    for (int i = 0; i < DEPTH; i++) begin
      mdl[i] = {3'(i), zf(3'(i))};
    end
  endtask

  // abort_at: edge index (after the start edge) on which abort is sampled, -1 for none.
  task automatic do_run(input int abort_at, input bit wr_w_start, input logic [3:0] wd,
                        input bit disturb);
    int ec, ef;
    bit ev;
    start = 1'b1;
    if (wr_w_start) begin
      wr_en = 1'b1; wr_addr = '0; wr_data = wd; mdl[0] = wd;
    end
    tick;
    start = 1'b0; wr_en = 1'b0;
    for (int k = 0; k < DEPTH*HOLD; k++) begin
      chk("run_busy", busy, 1);
      chk("run_abc", {a_out, b_out, c_out}, mdl[k/HOLD][3:1]);
      if (disturb && k == 5) begin
        wr_en = 1'b1; wr_addr = '0; wr_data = 4'b0000; start = 1'b1;
      end
      if (disturb && k == 6) begin
        wr_en = 1'b0; start = 1'b0;
      end
      if (abort_at == k + 1) begin
        abort = 1'b1;
        tick;
        abort = 1'b0;
        calc(k / HOLD, ec, ef, ev);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_pass", pass, 0);
        chk("abort_abc", {a_out, b_out, c_out}, 0);
        chk("abort_err_cnt", err_cnt, ec);
        chk("abort_err_valid", err_valid, ev);
        chk("abort_err_first", err_first, ef);
        tick;
        chk("abort_stays_idle", busy, 0);
        return;
      end
      tick;
    end
    calc(DEPTH, ec, ef, ev);
    chk("end_busy", busy, 0);
    chk("end_done", done, 1);
    chk("end_abc", {a_out, b_out, c_out}, 0);
    chk("end_pass", pass, (ec == 0));
    chk("end_err_cnt", err_cnt, ec);
    chk("end_err_valid", err_valid, ev);
    chk("end_err_first", err_first, ef);
    tick;
    chk("done_held", done, 1);
  endtask

  initial begin
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_abc", {a_out, b_out, c_out}, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_err_valid", err_valid, 0);
    rst_n = 1'b1;
    tick;

    // Correct truth table: clean pass.
    truth_tbl();
    load_tbl();
    do_run(-1, 1'b0, 4'h0, 1'b0);
    chk("t1_pass_const", pass, 1);

    // Two wrong expectations at entries 2 and 6.
    mdl[2] = 4'b0101; mdl[6] = 4'b1100;
    load_tbl();
    do_run(-1, 1'b0, 4'h0, 1'b0);
    chk("t2_err_cnt_const", err_cnt, 2);
    chk("t2_err_first_const", err_first, 2);

    // Abort at edge 10, then a full rerun from idx 0.
    do_run(10, 1'b0, 4'h0, 1'b0);
    do_run(-1, 1'b0, 4'h0, 1'b0);

    // Write and start during a run are ignored; a rerun shows entry 0 intact.
    truth_tbl();
    load_tbl();
    do_run(-1, 1'b0, 4'h0, 1'b1);
    do_run(-1, 1'b0, 4'h0, 1'b0);
    chk("t4_entry0_pass", pass, 1);

    // Asynchronous reset mid-run with errors already counted.
    mdl[2] = 4'b0101;
    load_tbl();
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (13) tick;
    chk("t5_pre_err_cnt", err_cnt, 1);
    chk("t5_pre_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 0);
    chk("t5_abc", {a_out, b_out, c_out}, 0);
    chk("t5_err_cnt", err_cnt, 0);
    #2 rst_n = 1'b1;
    tick;
    truth_tbl();
    load_tbl();
    do_run(-1, 1'b0, 4'h0, 1'b0);

    // start and abort together from DONE: abort wins, nothing runs.
    chk("t6_pre_done", done, 1);
    start = 1'b1; abort = 1'b1;
    tick;
    start = 1'b0; abort = 1'b0;
    chk("t6_busy", busy, 0);
    chk("t6_done", done, 0);
    chk("t6_pass", pass, 0);
    repeat (5) tick;
    chk("t6_still_idle", busy, 0);
    chk("t6_abc", {a_out, b_out, c_out}, 0);

    // Random tables; entry 0 rewritten on the start edge; some runs aborted.
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < DEPTH; i++) mdl[i] = 4'($urandom_range(0, 15));
      load_tbl();
      do_run((r % 3 == 2) ? int'($urandom_range(1, DEPTH*HOLD - 1)) : -1,
             1'b1, 4'($urandom_range(0, 15)), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vec_seq_ctrl.md
Name: vec_seq_ctrl

Overview:
- Self-checking test-vector sequencer for the 3-input combinational function block (a, b, c -> z).
- Holds a DEPTH-entry table of {a,b,c,expected}, loaded through a write port.
- On start, drives each vector onto the block inputs for HOLD cycles, samples z, compares it with the expected bit, and reports mismatch count, first failing index, and pass/done status.
- Sits between a host/bench and the combinational block; it replaces ad-hoc file-driven stimulus loops.

Parameters:
DEPTH, 8, number of table entries (power of two, at least 2)
ADDR_W, 3, log2(DEPTH)
HOLD, 4, cycles each vector is held before z is sampled (at least 1)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
wr_en  input  1  table write strobe; accepted only when busy=0
wr_addr  input  ADDR_W  table write index
wr_data  input  4  {a,b,c,exp}; bit3=a, bit0=exp
start  input  1  run request; accepted only when busy=0
abort  input  1  terminate run; return to IDLE
z_in  input  1  output of the combinational block under test
a_out, b_out, c_out  output  1 each  stimulus to the block under test
busy  output  1  run in progress
done  output  1  run completed; level held until next accepted start or abort
pass  output  1  done=1 and err_cnt=0
err_cnt  output  ADDR_W+1  number of mismatches in the current/last run
err_first  output  ADDR_W  index of the first mismatch; valid when err_valid=1
err_valid  output  1  at least one mismatch seen in the current/last run

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE, all outputs 0, idx=0, hold_cnt=0. Table contents are not reset; the bench must load the table before start.
- States: IDLE, RUN, DONE.
- IDLE/DONE with start=1:
  - Next state RUN; idx=0; hold_cnt=0.
  - err_cnt, err_valid, err_first, done and pass are cleared.
  - busy=1 from the next cycle.
- RUN: {a_out,b_out,c_out} = table[idx][3:1] on every cycle in RUN, registered.
  - hold_cnt counts 0..HOLD-1.
  - At the edge where hold_cnt=HOLD-1: compare z_in against table[idx][0].
    - On mismatch: err_cnt+1. If err_valid=0, err_first=idx and err_valid=1.
  - Then hold_cnt=0 and idx+1.
  - If idx=DEPTH-1 at that edge, go to DONE instead: busy=0, done=1, pass=(final err_cnt==0).
- Latency: done rises DEPTH*HOLD edges after the edge that accepted start (32 with defaults).
- err_cnt cannot overflow: its width is ADDR_W+1, maximum value DEPTH.
- In DONE, a/b/c outputs return to 0. The results hold until the next start.
- abort=1 in any state, sampled on the clock edge:
  - Go to IDLE; busy=0, done=0, pass=0; a/b/c=0.
  - err_cnt, err_first and err_valid keep their partial values.
  - abort has priority over start and over the sample edge in the same cycle.
- wr_en while busy=1 is ignored; the table is unchanged.
- wr_en and start in the same IDLE cycle: the write takes effect, and the run uses the updated entry.
- start while busy=1 is ignored.
- Reset asserted mid-run: immediate return to the reset values above. The next start reruns from idx 0.
- idx wrap never occurs; RUN always exits at DEPTH-1.

Test Plan:
1. Load the correct truth table for z=(a&b)|~(b&~c): exp=1 for every index except idx2 (abc=010, exp=0). Pulse start. Required: busy for 32 cycles, done=1, pass=1, err_cnt=0, err_valid=0, and a/b/c stepping 000..111 every 4 cycles.
2. Same table but entry 2 written with exp=1, and entry 6 (110) written with exp=0. Required: err_cnt=2, err_first=2, err_valid=1, pass=0, done=1.
3. Pulse abort at cycle 10 of a run. Required:
   - Next cycle: busy=0, done=0, a/b/c=000.
   - A subsequent start runs the full 32 cycles from idx 0.
4. During a run, write wr_addr=0 with 4'b0000 and pulse start. Required: both are ignored; results match scenario 1; after done, reading behaviour confirms entry 0 is unchanged.
5. Assert rst_n=0 asynchronously mid-run, without a clock edge. Required: busy, done, a/b/c and err_cnt go to 0 immediately. After release, start gives a full correct run.
6. Assert start and abort in the same cycle from DONE. Required: state IDLE, done=0, no run started.
